axi2mem_trans_unit_nlane: RTL and testbench

Parametrised data-path buffer between the AXI slave side and an N-lane TCDM port of axi2mem. Read data arrives per lane from TCDM and is merged into one wide beat carrying ID and LAST. Write beats are split into per-lane word+strobe FIFOs. New relative to the fixed 2-lane unit:
- configurable lane count, width and depths;
- ID propagated alongside LAST;
- optional suppression of all-zero-strobe lanes;
- synchronous flush;
- occupancy status outputs.

---
 rtl/axi2mem_pkg.sv | 12 +
 rtl/axi2mem_fifo_cnt.sv | 47 ++++
 rtl/axi2mem_trans_unit_nlane.sv | 91 +++++++++
 tb/tb_axi2mem_trans_unit_nlane.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// axi2mem_pkg: shared sizing helpers for the axi2mem N-lane data-path buffer
package axi2mem_pkg;
  function automatic int lane_strb(input int dw);
    return dw / 8;
  endfunction
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/axi2mem_fifo_cnt.sv
// axi2mem_fifo_cnt: registered FIFO of any depth with occupancy count and sync flush
module axi2mem_fifo_cnt
  import axi2mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        push_valid_i,
  output logic                        push_ready_o,
  input  logic [DATA_WIDTH-1:0]       push_data_i,
  output logic                        pop_valid_o,
  input  logic                        pop_ready_i,
  output logic [DATA_WIDTH-1:0]       pop_data_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);
  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push_ready_o = count_o != CW'(DEPTH);
  assign pop_valid_o  = count_o != '0;
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_ready_i & pop_valid_o;
  assign pop_data_o   = mem[rd_ptr];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count_o <= count_o + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/axi2mem_trans_unit_nlane.sv
// axi2mem_trans_unit_nlane: merges per-lane TCDM read data into AXI beats and splits AXI write beats per lane
module axi2mem_trans_unit_nlane
  import axi2mem_pkg::*;
#(
  parameter int NB_LANES          = 2,
  parameter int LANE_DW           = 32,
  parameter int ID_WIDTH          = 6,
  parameter int RD_DEPTH          = 2,
  parameter int WR_DEPTH          = 2,
  parameter int SB_DEPTH          = 8,
  parameter int WR_SKIP_ZERO_STRB = 0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [NB_LANES*LANE_DW-1:0]             rd_data_push_dat_i,
  input  logic [NB_LANES-1:0]                     rd_data_push_req_i,
  output logic [NB_LANES-1:0]                     rd_data_push_gnt_o,
  input  logic [ID_WIDTH-1:0]                     rd_data_push_id_i,
  input  logic                                    rd_data_push_last_i,
  output logic [NB_LANES*LANE_DW-1:0]             rd_data_pop_dat_o,
  input  logic                                    rd_data_pop_req_i,
  output logic                                    rd_data_pop_gnt_o,
  output logic [ID_WIDTH-1:0]                     rd_data_pop_id_o,
  output logic                                    rd_data_pop_last_o,
  input  logic [NB_LANES*LANE_DW-1:0]             wr_data_push_dat_i,
  input  logic [NB_LANES*LANE_DW/8-1:0]           wr_data_push_strb_i,
  input  logic                                    wr_data_push_req_i,
  output logic                                    wr_data_push_gnt_o,
  output logic [NB_LANES*LANE_DW-1:0]             wr_data_pop_dat_o,
  output logic [NB_LANES*LANE_DW/8-1:0]           wr_data_pop_strb_o,
  input  logic [NB_LANES-1:0]                     wr_data_pop_req_i,
  output logic [NB_LANES-1:0]                     wr_data_pop_gnt_o,
  output logic [$clog2(SB_DEPTH+1)-1:0]           rd_level_o,
  output logic [NB_LANES*$clog2(WR_DEPTH+1)-1:0]  wr_level_o
);
  localparam int LS  = lane_strb(LANE_DW);
  localparam int RCW = cnt_width(RD_DEPTH);
  localparam int WCW = cnt_width(WR_DEPTH);
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                last;
  } rd_sb_t;
  rd_sb_t sb_in, sb_out;
  logic [NB_LANES-1:0] rd_ready, rd_vld, rd_valid, wr_ready, wr_en, wr_push;
  logic sb_ready, sb_valid, rd_pop;
  assign sb_in              = '{id: rd_data_push_id_i, last: rd_data_push_last_i};
  assign rd_data_pop_gnt_o  = &rd_valid & sb_valid;
  assign rd_pop             = rd_data_pop_gnt_o & rd_data_pop_req_i;
  assign rd_data_pop_id_o   = sb_out.id;
  assign rd_data_pop_last_o = sb_out.last;
  assign wr_data_push_gnt_o = &(~wr_en | wr_ready);
  // ID and LAST travel in their own FIFO, pushed together with lane 0
  axi2mem_fifo_cnt #(.DATA_WIDTH($bits(rd_sb_t)), .DEPTH(SB_DEPTH)) u_sb (
    .clk_i, .rst_i, .flush_i,
    .push_valid_i(rd_data_push_req_i[0] & rd_ready[0]),
    .push_ready_o(sb_ready),
    .push_data_i (sb_in),
    .pop_valid_o (sb_valid),
    .pop_ready_i (rd_pop),
    .pop_data_o  (sb_out),
    .count_o     (rd_level_o)
  );
  for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
    logic [RCW-1:0] rd_cnt;
    assign rd_data_push_gnt_o[i] = rd_ready[i] & (i == 0 ? sb_ready : 1'b1);
    assign rd_valid[i] = rd_vld[i] & (rd_cnt != '0);
    assign wr_en[i]    = WR_SKIP_ZERO_STRB != 0 ? |wr_data_push_strb_i[i*LS +: LS] : 1'b1;
    assign wr_push[i]  = wr_data_push_req_i & wr_data_push_gnt_o & wr_en[i];
    axi2mem_fifo_cnt #(.DATA_WIDTH(LANE_DW), .DEPTH(RD_DEPTH)) u_rd (
      .clk_i, .rst_i, .flush_i,
      .push_valid_i(rd_data_push_req_i[i] & rd_data_push_gnt_o[i]),
      .push_ready_o(rd_ready[i]),
      .push_data_i (rd_data_push_dat_i[i*LANE_DW +: LANE_DW]),
      .pop_valid_o (rd_vld[i]),
      .pop_ready_i (rd_pop),
      .pop_data_o  (rd_data_pop_dat_o[i*LANE_DW +: LANE_DW]),
      .count_o     (rd_cnt)
    );
    axi2mem_fifo_cnt #(.DATA_WIDTH(LANE_DW + LS), .DEPTH(WR_DEPTH)) u_wr (
      .clk_i, .rst_i, .flush_i,
      .push_valid_i(wr_push[i]),
      .push_ready_o(wr_ready[i]),
      .push_data_i ({wr_data_push_strb_i[i*LS +: LS], wr_data_push_dat_i[i*LANE_DW +: LANE_DW]}),
      .pop_valid_o (wr_data_pop_gnt_o[i]),
      .pop_ready_i (wr_data_pop_req_i[i]),
      .pop_data_o  ({wr_data_pop_strb_o[i*LS +: LS], wr_data_pop_dat_o[i*LANE_DW +: LANE_DW]}),
      .count_o     (wr_level_o[i*WCW +: WCW])
    );
  end
endmodule

// File: tb/tb_axi2mem_trans_unit_nlane.sv
// tb_axi2mem_trans_unit_nlane: default 2-lane unit plus a 4-lane skip-zero-strobe unit with depth-3 write FIFOs
module tb_axi2mem_trans_unit_nlane;
  logic clk = 0, rst = 1, flush = 0;
  always #5 clk = ~clk;

  logic [63:0]  a_rd_push_dat = '0, a_rd_pop_dat, a_wr_push_dat = '0, a_wr_pop_dat;
  logic [1:0]   a_rd_push_req = '0, a_rd_push_gnt, a_wr_pop_req = '0, a_wr_pop_gnt;
  logic [5:0]   a_rd_push_id = '0, a_rd_pop_id;
  logic         a_rd_push_last = 0, a_rd_pop_last, a_rd_pop_req = 0, a_rd_pop_gnt;
  logic [7:0]   a_wr_push_strb = '0, a_wr_pop_strb;
  logic         a_wr_push_req = 0, a_wr_push_gnt;
  logic [3:0]   a_rd_level, a_wr_level;

  logic [127:0] b_rd_push_dat = '0, b_rd_pop_dat, b_wr_push_dat = '0, b_wr_pop_dat;
  logic [3:0]   b_rd_push_req = '0, b_rd_push_gnt, b_wr_pop_req = '0, b_wr_pop_gnt;
  logic [5:0]   b_rd_push_id = '0, b_rd_pop_id;
  logic         b_rd_push_last = 0, b_rd_pop_last, b_rd_pop_req = 0, b_rd_pop_gnt;
  logic [15:0]  b_wr_push_strb = '0, b_wr_pop_strb;
  logic         b_wr_push_req = 0, b_wr_push_gnt;
  logic [3:0]   b_rd_level;
  logic [7:0]   b_wr_level;

  axi2mem_trans_unit_nlane dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .rd_data_push_dat_i(a_rd_push_dat), .rd_data_push_req_i(a_rd_push_req), .rd_data_push_gnt_o(a_rd_push_gnt),
    .rd_data_push_id_i(a_rd_push_id), .rd_data_push_last_i(a_rd_push_last),
    .rd_data_pop_dat_o(a_rd_pop_dat), .rd_data_pop_req_i(a_rd_pop_req), .rd_data_pop_gnt_o(a_rd_pop_gnt),
    .rd_data_pop_id_o(a_rd_pop_id), .rd_data_pop_last_o(a_rd_pop_last),
    .wr_data_push_dat_i(a_wr_push_dat), .wr_data_push_strb_i(a_wr_push_strb), .wr_data_push_req_i(a_wr_push_req),
    .wr_data_push_gnt_o(a_wr_push_gnt), .wr_data_pop_dat_o(a_wr_pop_dat), .wr_data_pop_strb_o(a_wr_pop_strb),
    .wr_data_pop_req_i(a_wr_pop_req), .wr_data_pop_gnt_o(a_wr_pop_gnt),
    .rd_level_o(a_rd_level), .wr_level_o(a_wr_level)
  );

  axi2mem_trans_unit_nlane #(.NB_LANES(4), .WR_DEPTH(3), .WR_SKIP_ZERO_STRB(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .rd_data_push_dat_i(b_rd_push_dat), .rd_data_push_req_i(b_rd_push_req), .rd_data_push_gnt_o(b_rd_push_gnt),
    .rd_data_push_id_i(b_rd_push_id), .rd_data_push_last_i(b_rd_push_last),
    .rd_data_pop_dat_o(b_rd_pop_dat), .rd_data_pop_req_i(b_rd_pop_req), .rd_data_pop_gnt_o(b_rd_pop_gnt),
    .rd_data_pop_id_o(b_rd_pop_id), .rd_data_pop_last_o(b_rd_pop_last),
    .wr_data_push_dat_i(b_wr_push_dat), .wr_data_push_strb_i(b_wr_push_strb), .wr_data_push_req_i(b_wr_push_req),
    .wr_data_push_gnt_o(b_wr_push_gnt), .wr_data_pop_dat_o(b_wr_pop_dat), .wr_data_pop_strb_o(b_wr_pop_strb),
    .wr_data_pop_req_i(b_wr_pop_req), .wr_data_pop_gnt_o(b_wr_pop_gnt),
    .rd_level_o(b_rd_level), .wr_level_o(b_wr_level)
  );

  typedef struct {
    logic [63:0] dat;
    logic [5:0]  id;
    logic        last;
  } rd_exp_t;
  typedef struct {
    logic [15:0]  strb;
    logic [127:0] dat;
    logic         gnt;
    logic [7:0]   lvl;
  } wr_vec_t;

  rd_exp_t rd_q[$];
  logic [35:0] wq[4][$];
  wr_vec_t tbl[7];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: a transfer is committed at the next edge whenever valid&ready is seen here
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (a_rd_pop_gnt && a_rd_pop_req) begin
        if (rd_q.size() == 0) check("rd_unexpected_beat", 1, 0);
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_beat_dat", a_rd_pop_dat, e.dat);
          check("rd_beat_id", a_rd_pop_id, e.id);
          check("rd_beat_last", a_rd_pop_last, e.last);
        end
      end
      for (int l = 0; l < 4; l++)
        if (b_wr_pop_gnt[l] && b_wr_pop_req[l]) begin
          if (wq[l].size() == 0) check($sformatf("wr_lane%0d_unexpected", l), 1, 0);
          else check($sformatf("wr_lane%0d_word", l), {b_wr_pop_strb[4*l +: 4], b_wr_pop_dat[32*l +: 32]}, wq[l].pop_front());
        end
    end
  end

  function automatic int wq_total();
    return wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size();
  endfunction

  initial begin
    int cyc;
    logic [3:0] exp_v;
    tbl[0] = '{16'h00F0, {32'h0, 32'h0, 32'h11112222, 32'h33334444}, 1'b1, 8'h04};
    tbl[1] = '{16'h0000, {4{32'hDEADBEEF}}, 1'b1, 8'h04};
    tbl[2] = '{16'hF00F, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1, 8'h45};
    tbl[3] = '{16'h0102, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b1, 8'h56};
    tbl[4] = '{16'h000F, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1, 8'h57};
    tbl[5] = '{16'h000F, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0, 8'h57};
    tbl[6] = '{16'h0010, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b1, 8'h5B};

    #2;
    check("rst_rd_pop_gnt", a_rd_pop_gnt, 0);
    check("rst_rd_push_gnt", a_rd_push_gnt, 2'b11);
    check("rst_wr_push_gnt", a_wr_push_gnt, 1);
    check("rst_wr_pop_gnt", a_wr_pop_gnt, 0);
    check("rst_levels", {a_rd_level, a_wr_level}, 0);
    check("rst_rd_outputs", {a_rd_pop_dat, a_rd_pop_id, a_rd_pop_last}, 0);
    check("rst_b_gnts", {b_rd_push_gnt, b_rd_pop_gnt, b_wr_push_gnt}, 6'b111101);
    check("rst_b_wr_level", b_wr_level, 0);
    tick(); tick();
    rst = 0;
    tick();

    // Both lanes pushed together
    a_rd_pop_req = 1;
    a_rd_push_dat = {32'hB, 32'hA}; a_rd_push_id = 5; a_rd_push_last = 1; a_rd_push_req = 2'b11;
    #1 check("t1_push_gnt", a_rd_push_gnt, 2'b11);
    rd_q.push_back('{64'h0000000B_0000000A, 6'd5, 1'b1});
    tick();
    a_rd_push_req = 0; a_rd_push_id = 0; a_rd_push_last = 0;
    #1;
    check("t1_pop_gnt", a_rd_pop_gnt, 1);
    check("t1_pop_dat", a_rd_pop_dat, 64'h0000000B_0000000A);
    check("t1_pop_id_last", {a_rd_pop_id, a_rd_pop_last}, {6'd5, 1'b1});
    check("t1_level1", a_rd_level, 1);
    tick();
    check("t1_pop_gnt_after", a_rd_pop_gnt, 0);
    check("t1_level0", a_rd_level, 0);

    // Lane 1 lags lane 0 by two cycles
    a_rd_push_dat = {32'h0, 32'h10}; a_rd_push_id = 2; a_rd_push_req = 2'b01;
    #1 check("t2_lane0_gnt", a_rd_push_gnt[0], 1);
    rd_q.push_back('{64'h00000020_00000010, 6'd2, 1'b0});
    tick();
    a_rd_push_req = 0; a_rd_push_id = 0;
    #1 check("t2_gnt_wait1", a_rd_pop_gnt, 0);
    tick();
    check("t2_gnt_wait2", a_rd_pop_gnt, 0);
    a_rd_push_dat = {32'h20, 32'h0}; a_rd_push_req = 2'b10;
    #1 check("t2_gnt_wait3", a_rd_pop_gnt, 0);
    tick();
    a_rd_push_req = 0;
    #1 check("t2_gnt_ready", a_rd_pop_gnt, 1);
    tick();
    check("t2_gnt_done", a_rd_pop_gnt, 0);
    check("t2_one_beat", rd_q.size(), 0);

    // Fill to RD_DEPTH, refuse when full, pop and push together
    a_rd_pop_req = 0;
    a_rd_push_dat = {32'h2, 32'h1}; a_rd_push_id = 1; a_rd_push_last = 0; a_rd_push_req = 2'b11;
    #1 rd_q.push_back('{64'h00000002_00000001, 6'd1, 1'b0});
    tick();
    a_rd_push_dat = {32'h4, 32'h3}; a_rd_push_id = 2; a_rd_push_last = 1;
    #1 rd_q.push_back('{64'h00000004_00000003, 6'd2, 1'b1});
    tick();
    a_rd_push_dat = {32'h6, 32'h5}; a_rd_push_id = 9;
    #1;
    check("t3_full_gnt", a_rd_push_gnt, 2'b00);
    check("t3_level_full", a_rd_level, 2);
    tick();
    check("t3_level_refused", a_rd_level, 2);
    a_rd_pop_req = 1;
    #1 check("t3_full_pushpop_gnt", a_rd_push_gnt, 2'b00);
    tick();
    a_rd_push_req = 0;
    #1 check("t3_pop_only_level", a_rd_level, 1);
    a_rd_push_dat = {32'h8, 32'h7}; a_rd_push_id = 3; a_rd_push_last = 0; a_rd_push_req = 2'b11;
    #1 check("t3_pushpop_gnt", a_rd_push_gnt, 2'b11);
    rd_q.push_back('{64'h00000008_00000007, 6'd3, 1'b0});
    tick();
    a_rd_push_req = 0;
    #1 check("t3_pushpop_level", a_rd_level, 1);
    tick(); tick();
    check("t3_drained_level", a_rd_level, 0);
    check("t3_drained_q", rd_q.size(), 0);
    a_rd_pop_req = 0;

    // Table of write beats on the skip-zero-strobe unit with no lane popping
    for (int r = 0; r < 7; r++) begin
      b_wr_push_dat = tbl[r].dat; b_wr_push_strb = tbl[r].strb; b_wr_push_req = 1;
      #1 check($sformatf("tbl%0d_gnt", r), b_wr_push_gnt, tbl[r].gnt);
      for (int l = 0; l < 4; l++)
        if (tbl[r].gnt && tbl[r].strb[4*l +: 4] != 4'h0)
          wq[l].push_back({tbl[r].strb[4*l +: 4], tbl[r].dat[32*l +: 32]});
      tick();
      b_wr_push_req = 0;
      #1;
      for (int l = 0; l < 4; l++) exp_v[l] = tbl[r].lvl[2*l +: 2] != 2'd0;
      check($sformatf("tbl%0d_level", r), b_wr_level, tbl[r].lvl);
      check($sformatf("tbl%0d_valid", r), b_wr_pop_gnt, exp_v);
    end
    b_wr_pop_req = 4'hF;
    cyc = 0;
    while (wq_total() != 0 && cyc < 40) begin tick(); cyc++; end
    check("tbl_drain_in_time", cyc < 40, 1);
    tick();
    check("tbl_drained_level", b_wr_level, 0);

    // Lane 2 stalls a depth-3 FIFO, then its pointer wraps
    b_wr_pop_req = 4'b1011; b_wr_push_strb = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      for (int l = 0; l < 4; l++) b_wr_push_dat[32*l +: 32] = 32'hC000_0000 | (k << 8) | l;
      b_wr_push_req = 1;
      #1;
      if (k < 3) check($sformatf("wrap_gnt%0d", k), b_wr_push_gnt, 1);
      if (k == 3) begin
        check("wrap_stall_gnt", b_wr_push_gnt, 0);
        check("wrap_lane2_level", b_wr_level[5:4], 3);
        b_wr_pop_req = 4'hF;
      end
      cyc = 0;
      while (!b_wr_push_gnt && cyc < 20) begin @(posedge clk); #3; cyc++; end
      check($sformatf("wrap_accept%0d_in_time", k), cyc < 20, 1);
      for (int l = 0; l < 4; l++) wq[l].push_back({4'hF, b_wr_push_dat[32*l +: 32]});
      tick();
      b_wr_push_req = 0;
    end
    cyc = 0;
    while (wq_total() != 0 && cyc < 40) begin tick(); cyc++; end
    check("wrap_drain_in_time", cyc < 40, 1);
    tick();
    check("wrap_drained_level", b_wr_level, 0);
    b_wr_pop_req = 0; b_wr_push_strb = 0;

    // Flush with pushes and pops pending
    a_rd_push_req = 2'b11; a_rd_push_dat = {32'h31, 32'h30}; a_rd_push_id = 3;
    tick(); tick();
    a_rd_push_req = 0;
    a_wr_push_dat = {32'h55556666, 32'h77778888}; a_wr_push_strb = 8'h00; a_wr_push_req = 1;
    tick();
    a_wr_push_req = 0;
    #1;
    check("fl_rd_level_full", a_rd_level, 2);
    check("fl_wr_level_zero_strb", a_wr_level, 4'b0101);
    check("fl_wr_lane0", {a_wr_pop_strb[3:0], a_wr_pop_dat[31:0]}, {4'h0, 32'h77778888});
    check("fl_wr_valid", a_wr_pop_gnt, 2'b11);
    flush = 1; a_rd_pop_req = 1; a_rd_push_req = 2'b11; a_wr_push_req = 1; a_wr_pop_req = 2'b11;
    tick();
    flush = 0; a_rd_pop_req = 0; a_rd_push_req = 0; a_wr_push_req = 0; a_wr_pop_req = 0;
    #1;
    check("fl_valids", {a_rd_pop_gnt, a_wr_pop_gnt}, 0);
    check("fl_levels", {a_rd_level, a_wr_level}, 0);
    check("fl_push_gnts", {a_rd_push_gnt, a_wr_push_gnt}, 3'b111);

    // Asynchronous reset in the middle of a cycle
    a_rd_push_dat = {32'hBB, 32'hAA}; a_rd_push_id = 7; a_rd_push_last = 1; a_rd_push_req = 2'b11;
    tick();
    a_rd_push_req = 0;
    #1;
    check("ar_gnt_before", a_rd_pop_gnt, 1);
    check("ar_level_before", a_rd_level, 1);
    #2 rst = 1;
    #1;
    check("ar_gnt", a_rd_pop_gnt, 0);
    check("ar_level", a_rd_level, 0);
    check("ar_outputs", {a_rd_pop_dat, a_rd_pop_id, a_rd_pop_last}, 0);
    tick();
    rst = 0;
    tick();
    check("ar_push_gnt", a_rd_push_gnt, 2'b11);

    check("end_rd_queue_empty", rd_q.size(), 0);
    check("end_wr_queue_empty", wq_total(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
